mult_div_unit: RTL and testbench

//  Parametrised multicycle multiply/divide unit for the multicycle CPU datapath; feeds HI/LO.

---
 rtl/mult_div_unit_pkg.sv | 24 ++
 rtl/multdiv_magnitude_core.sv | 73 +++++++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op and FSM state encodings.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_DIV   = 2'b01,
    MD_MULTU = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Bit 0 of the op code separates divide from multiply in both signed and unsigned forms.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/multdiv_magnitude_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// acc holds the running high half / remainder, quo the multiplier bits / quotient.
module multdiv_magnitude_core
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q;
  logic             mode_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_diff;

  // One iteration of the selected algorithm.
  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, opb_q};
    shifted     = {acc_q, quo_q[WIDTH-1]};
    diff        = {1'b0, shifted} - {2'b00, opb_q};
    borrow      = diff[WIDTH+1];
    unused_diff = diff[WIDTH];
    acc_d       = acc_q;
    quo_d       = quo_q;
    if (mode_q) begin
      // Restoring divide: keep the trial difference only when it did not go negative.
      acc_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~borrow};
    end else if (quo_q[0]) begin
      acc_d = sum[WIDTH:1];
      quo_d = {sum[0], quo_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[WIDTH-1:1]};
      quo_d = {acc_q[0], quo_q[WIDTH-1:1]};
    end
  end

  // Operand load and per-step update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      quo_q  <= '0;
      opb_q  <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      acc_q  <= '0;
      quo_q  <= op_a;
      opb_q  <= op_b;
      mode_q <= div_mode;
    end else if (step) begin
      acc_q <= acc_d;
      quo_q <= quo_d;
    end
  end

  assign acc = acc_q;
  assign quo = quo_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit feeding HI/LO. Owns the FSM, step counter, sign handling
// and result registers; the magnitude datapath lives in multdiv_magnitude_core.
// Optional feature: define MULTDIV_UNSIGNED_EN to honour op[1] (multu/divu).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             core_load, core_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] core_acc, core_quo;
  logic [2*WIDTH-1:0] prod_neg;
  logic             start_signed;

`ifdef MULTDIV_UNSIGNED_EN
  assign start_signed = ~op[1];
`else
  logic unused_op_hi;
  assign unused_op_hi = op[1];
  assign start_signed = 1'b1;
`endif

  // Magnitudes wrap at WIDTH bits, so MIN maps to itself and still reads as 2**(WIDTH-1).
  assign mag_a    = (is_signed_q && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
  assign mag_b    = (is_signed_q && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;
  assign prod_neg = '0 - {core_acc, core_quo};

  multdiv_magnitude_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (core_load),
    .step    (core_step),
    .div_mode(is_div_q),
    .op_a    (mag_a),
    .op_b    (mag_b),
    .acc     (core_acc),
    .quo     (core_quo)
  );

  // Next-state, datapath control and status outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dz_d        = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (start) begin
          state_d     = ST_PREP;
          a_d         = a;
          b_d         = b;
          is_div_d    = op_is_div(op);
          is_signed_d = start_signed;
        end
      end
      ST_PREP: begin
        busy     = 1'b1;
        // lo (product / quotient) negates on differing signs; remainder follows the dividend.
        neg_lo_d = is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi_d = is_signed_q & a_q[WIDTH-1];
        if (is_div_q && (b_q == '0)) begin
          state_d = ST_DONE;
          dz_d    = 1'b1;
        end else begin
          state_d   = ST_RUN;
          core_load = 1'b1;
          cnt_d     = CntW'(WIDTH - 1);
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        core_step = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        busy    = 1'b1;
        state_d = ST_DONE;
        if (is_div_q) begin
          lo_d = neg_lo_q ? ('0 - core_quo) : core_quo;
          hi_d = neg_hi_q ? ('0 - core_acc) : core_acc;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : {core_acc, core_quo};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dz_q        <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH=32): arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } res_t;

  // Plain-arithmetic reference for one operation.
  function automatic res_t model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    res_t r;
    logic uns;
    logic signed [2*W-1:0] ea, eb, t;
    uns = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
    uns = mop[1];
`endif
    ea = uns ? {{W{1'b0}}, ma} : {{W{ma[W-1]}}, ma};
    eb = uns ? {{W{1'b0}}, mb} : {{W{mb[W-1]}}, mb};
    r = '0;
    if (!mop[0]) begin
      t = ea * eb;
      r.hi = t[2*W-1:W];
      r.lo = t[W-1:0];
    end else if (mb == '0) begin
      r.dz = 1'b1;
    end else begin
      t = ea / eb;
      r.lo = t[W-1:0];
      t = ea % eb;
      r.hi = t[W-1:0];
    end
    return r;
  endfunction

  // Timeline model: phase counts cycles since acceptance; the done cycle is phase == m_len.
  res_t         m_res = '0;
  int           m_phase = 0;
  int           m_len = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_len   <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_res   <= '0;
    end else if (m_phase != 0 && m_phase < m_len) begin
      m_phase <= m_phase + 1;
      if (m_phase + 1 == m_len && !m_res.dz) begin
        m_hi <= m_res.hi;
        m_lo <= m_res.lo;
      end
    end else if (start) begin
      m_res   <= model(op, a, b);
      m_len   <= (op[0] && b == '0) ? 2 : int'(W) + 3;
      m_phase <= 1;
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = (m_phase != 0) && (m_phase < m_len);
    e_done = (m_phase != 0) && (m_phase == m_len);
    check("cyc busy", 64'(busy), 64'(e_busy));
    check("cyc done", 64'(done), 64'(e_done));
    check("cyc div_zero", 64'(div_zero), 64'(e_done && m_res.dz));
    check("cyc hi", 64'(hi), 64'(m_hi));
    check("cyc lo", 64'(lo), 64'(m_lo));
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Cycles from the start cycle to the done cycle; operands are scrambled once accepted.
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= int'(W) + 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 2'($urandom);
      end
      @(negedge clk);
      if (done) begin
        k = i;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: no done within %0d cycles", W + 8);
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int lat, input logic [W-1:0] eh,
                     input logic [W-1:0] el, input logic edz, input logic chain);
    int k;
    if (!chain) begin
      @(posedge clk);
      #1;
    end
    issue(o, x, y);
    wait_done(k);
    check({nm, " latency"}, 64'(k), 64'(lat));
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    check({nm, " div_zero"}, 64'(div_zero), 64'(edz));
  endtask

  initial begin
    int k;
    logic seen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 35, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run("div MIN/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h0, 32'h8000_0000, 1'b0,
        1'b0);
    run("div 5/0", MD_DIV, 32'd5, 32'd0, 2, 32'h0, 32'h8000_0000, 1'b1, 1'b0);
    run("mult 2*3 chained", MD_MULT, 32'd2, 32'd3, 35, 32'h0, 32'h6, 1'b0, 1'b1);
    run("div 100/7", MD_DIV, 32'd100, 32'd7, 35, 32'h2, 32'hE, 1'b0, 1'b0);
    run("mult MIN*MIN", MD_MULT, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000, 32'h0, 1'b0,
        1'b0);
    run("mult x*0", MD_MULT, 32'd12345, 32'd0, 35, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
    run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 35, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd2, 35, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0);
`else
    run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd2, 35, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
`endif

    // Further starts while busy must be dropped.
    @(posedge clk);
    #1 issue(MD_MULT, 32'd100, 32'd200);
    k = 0;
    for (int i = 1; i <= int'(W) + 8 && k == 0; i++) begin
      @(posedge clk);
      #1;
      start = (i >= 3 && i <= 6);
      a     = W'(i);
      b     = 32'd9;
      op    = MD_DIV;
      @(negedge clk);
      if (done) k = i;
    end
    start = 1'b0;
    check("ignored latency", 64'(k), 64'd35);
    check("ignored hi", 64'(hi), 64'd0);
    check("ignored lo", 64'(lo), 64'h4E20);

    // Reset in the middle of an operation.
    @(posedge clk);
    #1 issue(MD_MULT, 32'd7, 32'd9);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midreset no done", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
